// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller: register
// function codes and the controller state encoding.
package mult_pkg;

  // Function codes driven to the x / y / accumulator registers
  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] LOAD   = 2'b01;
  localparam logic [1:0] SHIFTR = 2'b10;
  localparam logic [1:0] RESET  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TEST,
    ST_ADD,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mult_step_cnt.sv
// Multiplier step counter: cleared at operand load, advanced once per shift,
// flags the final step. Saturates at STEPS-1 so it can never wrap.
module mult_step_cnt #(
  parameter int STEPS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam int            CW   = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && !tc)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/mult_ctrl.sv
// Moore controller for a shift-add multiplier datapath (x, y, acc registers).
// Define MULT_CTRL_EARLY_EXIT_EN to finish as soon as the multiplier is zero.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int STEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_lsb,
  input  logic       y_zero,
  output logic [1:0] func_x,
  output logic [1:0] func_y,
  output logic [1:0] func_acc,
  output logic       x_sel,
  output logic       acc_sel,
  output logic       busy,
  output logic       done
);

  state_t state, state_n;
  logic   last_step;

`ifndef MULT_CTRL_EARLY_EXIT_EN
  // Multiplier-zero status only matters when early exit is built in
  logic unused_y_zero;
  assign unused_y_zero = y_zero;
`endif

  mult_step_cnt #(.STEPS(STEPS)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == ST_LOAD),
    .inc (state == ST_SHIFT),
    .tc  (last_step)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    func_x   = HOLD;
    func_y   = HOLD;
    func_acc = HOLD;
    x_sel    = 1'b0;
    acc_sel  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        func_x   = LOAD;
        func_y   = LOAD;
        func_acc = RESET;
        busy     = 1'b1;
        state_n  = ST_TEST;
      end
      ST_TEST: begin
        busy = 1'b1;
`ifdef MULT_CTRL_EARLY_EXIT_EN
        if (y_zero)     state_n = ST_DONE;
        else if (y_lsb) state_n = ST_ADD;
        else            state_n = ST_SHIFT;
`else
        state_n = y_lsb ? ST_ADD : ST_SHIFT;
`endif
      end
      ST_ADD: begin
        func_acc = LOAD;
        acc_sel  = 1'b1;
        busy     = 1'b1;
        state_n  = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Multiplicand doubles while the multiplier shifts toward its LSB
        func_x  = LOAD;
        x_sel   = 1'b1;
        func_y  = SHIFTR;
        busy    = 1'b1;
        state_n = last_step ? ST_DONE : ST_TEST;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl: stimulus queues per-cycle expected states,
// done cycles and final accumulator values; a negedge monitor compares.
module tb_mult_ctrl;

  localparam int STEPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       y_lsb, y_zero;
  logic [1:0] func_x, func_y, func_acc;
  logic       x_sel, acc_sel, busy, done;

  always #5 clk = ~clk;

  mult_ctrl #(.STEPS(STEPS)) dut (
    .clk(clk), .rst(rst), .start(start), .y_lsb(y_lsb), .y_zero(y_zero),
    .func_x(func_x), .func_y(func_y), .func_acc(func_acc),
    .x_sel(x_sel), .acc_sel(acc_sel), .busy(busy), .done(done)
  );

  // Either directly driven status bits or a 4-bit datapath slaved to the DUT
  logic       dp_mode = 1'b0, ylsb_drv = 1'b0, yz_drv = 1'b0;
  logic [3:0] in_x = 4'd0, in_y = 4'd0;
  logic [3:0] dp_x = 4'd0, dp_y = 4'd0, dp_acc = 4'd0;

  assign y_lsb  = dp_mode ? dp_y[0] : ylsb_drv;
  assign y_zero = dp_mode ? (dp_y == 4'd0) : yz_drv;

  always @(posedge clk) begin
    case (func_x)
      2'b01:   dp_x <= x_sel ? {dp_x[2:0], 1'b0} : in_x;
      2'b10:   dp_x <= dp_x >> 1;
      2'b11:   dp_x <= 4'd0;
      default: ;
    endcase
    case (func_y)
      2'b01:   dp_y <= in_y;
      2'b10:   dp_y <= dp_y >> 1;
      2'b11:   dp_y <= 4'd0;
      default: ;
    endcase
    case (func_acc)
      2'b01:   dp_acc <= acc_sel ? dp_acc + dp_x : dp_acc;
      2'b10:   dp_acc <= dp_acc >> 1;
      2'b11:   dp_acc <= 4'd0;
      default: ;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { byte st; string tag; } exp_t;
  exp_t       exp_q[$];
  int         done_q[$];
  logic [3:0] acc_q[$];

  int pass_cnt = 0, total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // {func_x, func_y, func_acc, x_sel, acc_sel, busy, done} per state letter
  function automatic logic [9:0] expv(input byte st);
    case (st)
      "I":     return 10'b00_00_00_0_0_0_0;
      "L":     return 10'b01_01_11_0_0_1_0;
      "T":     return 10'b00_00_00_0_0_1_0;
      "A":     return 10'b00_00_01_0_1_1_0;
      "S":     return 10'b01_10_00_1_0_1_0;
      "D":     return 10'b00_00_00_0_0_0_1;
      default: return 10'bxx_xx_xx_x_x_x_x;
    endcase
  endfunction

  wire [9:0] outv = {func_x, func_y, func_acc, x_sel, acc_sel, busy, done};

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.st != "-")
        check($sformatf("%s cyc%0d state %c outputs", e.tag, cyc, e.st), {22'd0, outv}, {22'd0, expv(e.st)});
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) check("unexpected_done cyc", cyc, 0);
      else check("done_cycle", cyc, done_q.pop_front());
      if (dp_mode && acc_q.size() > 0) check("accumulator_at_done", {28'd0, dp_acc}, {28'd0, acc_q.pop_front()});
    end
  end

  // Apply inputs for the next edge; afterwards the DUT should sit in state st
  task automatic step(input string tag, input byte st, input logic s, input logic r);
    start = s;
    rst   = r;
    @(posedge clk);
    #1;
    exp_q.push_back('{st, tag});
  endtask

  // seq[i] is the expected state in cycle i+1; start high for the first start_edges edges
  task automatic run(input string tag, input string seq, input int start_edges, input int d1, input int d2);
    int c0;
    c0 = cyc;
    if (d1 > 0) done_q.push_back(c0 + d1);
    if (d2 > 0) done_q.push_back(c0 + d2);
    for (int i = 0; i < seq.len(); i++) step(tag, seq[i], i < start_edges, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset overrides start
    @(posedge clk); #1;
    step("reset", "I", 1'b1, 1'b1);
    step("reset", "I", 1'b1, 1'b1);
    step("reset_idle", "I", 1'b0, 1'b0);
    step("reset_idle", "I", 1'b0, 1'b0);

    ylsb_drv = 1'b0; yz_drv = 1'b0;
    run("all_zero_bits", "LTSTSTSTSDII", 1, 10, 0);

    ylsb_drv = 1'b1;
    run("all_one_bits", "LTASTASTASTASDII", 1, 14, 0);

    // Start held through busy phase and DONE: restart two cycles after DONE
    run("start_held", {"LTASTASTASTASDI", "LTASTASTASTASDII"}, 16, 14, 29);

    // Reset in the middle of a SHIFT, with start also asserted
    ylsb_drv = 1'b0;
    step("rst_mid_shift", "L", 1'b1, 1'b0);
    step("rst_mid_shift", "T", 1'b0, 1'b0);
    step("rst_mid_shift", "S", 1'b0, 1'b0);
    step("rst_mid_shift", "I", 1'b1, 1'b1);
    step("rst_mid_shift", "I", 1'b0, 1'b0);
    step("rst_mid_shift", "I", 1'b0, 1'b0);
    run("after_reset", "LTSTSTSTSDI", 1, 10, 0);

    yz_drv = 1'b1;
`ifdef MULT_CTRL_EARLY_EXIT_EN
    run("early_exit", "LTDII", 1, 3, 0);
`else
    run("y_zero_ignored", "LTSTSTSTSDI", 1, 10, 0);
`endif
    yz_drv = 1'b0;

    // 5 * 3 through the slaved datapath
    in_x = 4'd5; in_y = 4'd3; dp_mode = 1'b1;
    acc_q.push_back(4'd15);
`ifdef MULT_CTRL_EARLY_EXIT_EN
    run("dp_5x3", "LTASTASTDII", 1, 9, 0);
`else
    run("dp_5x3", "LTASTASTSTSDII", 1, 12, 0);
`endif
    dp_mode = 1'b0;

    step("tail", "I", 1'b0, 1'b0);
    @(negedge clk); #1;
    check("done_queue_drained", done_q.size(), 0);
    check("acc_queue_drained", acc_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
